// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcode and ALU-op encodings,
// instruction field positions and the registered control bundle layout.
package decode_pkg;

  // Instruction field positions.
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 27;
  localparam int RD_MSB    = 26;
  localparam int RD_LSB    = 22;
  localparam int RS_MSB    = 21;
  localparam int RS_LSB    = 17;
  localparam int RT_MSB    = 16;
  localparam int RT_LSB    = 12;
  localparam int ALUOP_MSB = 6;
  localparam int ALUOP_LSB = 2;
  localparam int REGW      = 5;

  // Opcodes.
  localparam logic [4:0] OP_ALU  = 5'd0;
  localparam logic [4:0] OP_J    = 5'd1;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_JAL  = 5'd3;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;
  localparam logic [4:0] OP_SETX = 5'd9;
  localparam logic [4:0] OP_BEX  = 5'd10;

  // ALU-op encodings that select the multi-cycle unit.
  localparam logic [4:0] ALU_MULT = 5'd6;
  localparam logic [4:0] ALU_DIV  = 5'd7;

  // Control bundle; md_start here means "is a mult/div" and is qualified
  // with the valid bit where the bundle is driven out.
  typedef struct packed {
    logic jump;
    logic j2;
    logic bne;
    logic blt;
    logic bex;
    logic we_dm;
    logic we_reg;
    logic we_reg_dm;
    logic we_status;
    logic we_return;
    logic alu_op;
    logic immediate;
    logic mult;
    logic div;
    logic md_start;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode/ALU-op to control-bundle decoder.
module ctrl_decode
  import decode_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] alu_func,
  output ctrl_t          ctrl
);

  logic is_alu, is_j, is_bne, is_jal, is_jr, is_addi;
  logic is_blt, is_sw, is_lw, is_setx, is_bex;

  assign is_alu  = (opcode == OPW'(OP_ALU));
  assign is_j    = (opcode == OPW'(OP_J));
  assign is_bne  = (opcode == OPW'(OP_BNE));
  assign is_jal  = (opcode == OPW'(OP_JAL));
  assign is_jr   = (opcode == OPW'(OP_JR));
  assign is_addi = (opcode == OPW'(OP_ADDI));
  assign is_blt  = (opcode == OPW'(OP_BLT));
  assign is_sw   = (opcode == OPW'(OP_SW));
  assign is_lw   = (opcode == OPW'(OP_LW));
  assign is_setx = (opcode == OPW'(OP_SETX));
  assign is_bex  = (opcode == OPW'(OP_BEX));

  // Build the control bundle from the one-hot opcode flags.
  always_comb begin
    // NOTE: default every field first so no path leaves a field unassigned
    // (which would infer a latch).
    ctrl           = '0;
    ctrl.jump      = is_j | is_jal | is_jr;
    ctrl.j2        = is_jr;
    ctrl.bne       = is_bne;
    ctrl.blt       = is_blt;
    ctrl.bex       = is_bex;
    ctrl.we_dm     = is_sw;
    ctrl.we_reg    = is_alu | is_jal | is_addi | is_lw | is_setx;
    ctrl.we_reg_dm = is_lw;
    ctrl.we_status = is_alu | is_setx | is_addi;
    ctrl.we_return = is_jal;
    ctrl.alu_op    = is_alu | is_addi;
    ctrl.immediate = is_bne | is_lw | is_sw | is_blt | is_addi;
    ctrl.mult      = is_alu & (alu_func == OPW'(ALU_MULT));
    ctrl.div       = is_alu & (alu_func == OPW'(ALU_DIV));
    ctrl.md_start  = ctrl.mult | ctrl.div;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake, flush, and the mult/div
// interlock that holds off dependent or conflicting instructions.
module decode_stage
  import decode_pkg::*;
#(
  parameter int OPW       = 5,
  parameter int MD_CYCLES = 32,
  parameter int MD_HAZARD = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_jump,
  output logic        out_j2,
  output logic        out_bne,
  output logic        out_blt,
  output logic        out_bex,
  output logic        out_weDM,
  output logic        out_weReg,
  output logic        out_weRegDM,
  output logic        out_weStatus,
  output logic        out_weReturn,
  output logic        out_ALUop,
  output logic        out_immediate,
  output logic        out_mult,
  output logic        out_div,
  output logic        out_md_start,
  output logic        md_busy,
  output logic        stall
);

  localparam int CW = $clog2(MD_CYCLES + 1);

  ctrl_t           dec;
  ctrl_t           ctrl_q;
  logic            busy_q;
  logic [CW-1:0]   count;
  logic [REGW-1:0] md_rd;
  logic [REGW-1:0] f_rd, f_rs, f_rt;
  logic            conflict, hazard, accept;

  ctrl_decode #(.OPW(OPW)) u_ctrl_decode (
    .opcode   (in_instr[OPC_MSB -: OPW]),
    .alu_func (in_instr[ALUOP_MSB -: OPW]),
    .ctrl     (dec)
  );

  assign f_rd = in_instr[RD_MSB:RD_LSB];
  assign f_rs = in_instr[RS_MSB:RS_LSB];
  assign f_rt = in_instr[RT_MSB:RT_LSB];

  // Register 0 is never a real destination, so it never conflicts.
  assign conflict = (md_rd != '0) &&
                    ((f_rd == md_rd) || (f_rs == md_rd) || (f_rt == md_rd));

  // Hazard uses the registered busy flag, so an op arriving in the cycle
  // busy clears still waits one cycle.
  assign md_busy  = (MD_HAZARD != 0) & busy_q;
  assign hazard   = md_busy & (dec.md_start | dec.bex | conflict);
  assign stall    = in_valid & hazard;
  assign in_ready = !flush & !hazard & (!out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // Output bundle register: flush squashes, accept loads, consume clears.
  always_ff @(posedge clock) begin
    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      ctrl_q    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_instr <= in_instr;
      ctrl_q    <= dec;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Mult/div tracker: load on issue, count down, drop busy after count 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= 1'b0;
      count  <= '0;
      md_rd  <= '0;
    end else if (accept && dec.md_start) begin
      busy_q <= 1'b1;
      count  <= CW'(MD_CYCLES - 1);
      md_rd  <= f_rd;
    end else if (busy_q) begin
      if (count == '0) begin
        busy_q <= 1'b0;
      end else begin
        count <= count - CW'(1);
      end
    end
  end

  assign out_jump      = ctrl_q.jump;
  assign out_j2        = ctrl_q.j2;
  assign out_bne       = ctrl_q.bne;
  assign out_blt       = ctrl_q.blt;
  assign out_bex       = ctrl_q.bex;
  assign out_weDM      = ctrl_q.we_dm;
  assign out_weReg     = ctrl_q.we_reg;
  assign out_weRegDM   = ctrl_q.we_reg_dm;
  assign out_weStatus  = ctrl_q.we_status;
  assign out_weReturn  = ctrl_q.we_return;
  assign out_ALUop     = ctrl_q.alu_op;
  assign out_immediate = ctrl_q.immediate;
  assign out_mult      = ctrl_q.mult;
  assign out_div       = ctrl_q.div;
  assign out_md_start  = out_valid & ctrl_q.md_start;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage with a 4-cycle mult/div unit.
module tb_decode_stage;

  logic        clock, reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, out_instr;
  logic out_jump, out_j2, out_bne, out_blt, out_bex, out_weDM, out_weReg;
  logic out_weRegDM, out_weStatus, out_weReturn, out_ALUop, out_immediate;
  logic out_mult, out_div, out_md_start, md_busy, stall;

  int checks = 0;
  int failures = 0;

  decode_stage #(.OPW(5), .MD_CYCLES(4), .MD_HAZARD(1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_jump(out_jump),
    .out_j2(out_j2), .out_bne(out_bne), .out_blt(out_blt), .out_bex(out_bex),
    .out_weDM(out_weDM), .out_weReg(out_weReg), .out_weRegDM(out_weRegDM),
    .out_weStatus(out_weStatus), .out_weReturn(out_weReturn),
    .out_ALUop(out_ALUop), .out_immediate(out_immediate), .out_mult(out_mult),
    .out_div(out_div), .out_md_start(out_md_start), .md_busy(md_busy),
    .stall(stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected-control masks, bit order matches obs().
  localparam logic [14:0] C_JUMP = 15'h4000, C_J2 = 15'h2000, C_BNE = 15'h1000;
  localparam logic [14:0] C_BLT = 15'h0800, C_BEX = 15'h0400, C_WEDM = 15'h0200;
  localparam logic [14:0] C_WEREG = 15'h0100, C_WERDM = 15'h0080;
  localparam logic [14:0] C_WEST = 15'h0040, C_WERET = 15'h0020;
  localparam logic [14:0] C_ALUOP = 15'h0010, C_IMM = 15'h0008;
  localparam logic [14:0] C_MULT = 15'h0004, C_DIV = 15'h0002, C_MDS = 15'h0001;

  function automatic logic [14:0] obs();
    return {out_jump, out_j2, out_bne, out_blt, out_bex, out_weDM, out_weReg,
            out_weRegDM, out_weStatus, out_weReturn, out_ALUop, out_immediate,
            out_mult, out_div, out_md_start};
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] fn);
    return {op, rd, rs, rt, 5'd0, fn, 2'b00};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [14:0] ctrl;
  } vec_t;

  vec_t vt[12];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a_i, b_i, c_i, m5, add5, add6, m0, add0, dv, bx, m9;
    int busy_cycles;
    bit got;

    vt[0]  = '{"add",  mk(5'd0,  5'd1, 5'd2, 5'd3, 5'd0), C_WEREG | C_WEST | C_ALUOP};
    vt[1]  = '{"addi", mk(5'd5,  5'd4, 5'd2, 5'd0, 5'd0), C_WEREG | C_WEST | C_ALUOP | C_IMM};
    vt[2]  = '{"lw",   mk(5'd8,  5'd3, 5'd1, 5'd0, 5'd0), C_WEREG | C_WERDM | C_IMM};
    vt[3]  = '{"sw",   mk(5'd7,  5'd3, 5'd1, 5'd0, 5'd0), C_WEDM | C_IMM};
    vt[4]  = '{"jal",  mk(5'd3,  5'd0, 5'd0, 5'd0, 5'd0), C_JUMP | C_WERET | C_WEREG};
    vt[5]  = '{"jr",   mk(5'd4,  5'd31, 5'd0, 5'd0, 5'd0), C_JUMP | C_J2};
    vt[6]  = '{"j",    mk(5'd1,  5'd0, 5'd0, 5'd0, 5'd0), C_JUMP};
    vt[7]  = '{"bne",  mk(5'd2,  5'd1, 5'd2, 5'd0, 5'd0), C_BNE | C_IMM};
    vt[8]  = '{"blt",  mk(5'd6,  5'd1, 5'd2, 5'd0, 5'd0), C_BLT | C_IMM};
    vt[9]  = '{"setx", mk(5'd9,  5'd0, 5'd0, 5'd0, 5'd0), C_WEREG | C_WEST};
    vt[10] = '{"bex",  mk(5'd10, 5'd0, 5'd0, 5'd0, 5'd0), C_BEX};
    vt[11] = '{"op15", mk(5'd15, 5'd1, 5'd1, 5'd1, 5'd6), 15'h0000};

    // Reset state.
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_ctrl", 32'(obs()), 32'd0);
    check("rst_md_busy", 32'(md_busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_md_busy", 32'(md_busy), 32'd0);
    tick();

    // Streamed decode table, out_ready held high.
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_instr = vt[i].instr;
      @(negedge clock);
      check({vt[i].name, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
      check({vt[i].name, "_valid"}, 32'(out_valid), 32'd1);
      check({vt[i].name, "_instr"}, out_instr, vt[i].instr);
      check({vt[i].name, "_ctrl"}, 32'(obs()), 32'(vt[i].ctrl));
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: A held for 3 cycles while B waits.
    a_i = mk(5'd7, 5'd1, 5'd2, 5'd0, 5'd0);
    b_i = mk(5'd8, 5'd2, 5'd3, 5'd0, 5'd0);
    c_i = mk(5'd5, 5'd3, 5'd4, 5'd0, 5'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = a_i;
    tick();
    in_instr = b_i;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_instr", out_instr, a_i);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_b_instr", out_instr, b_i);
    check("bp_b_valid", 32'(out_valid), 32'd1);
    in_instr = c_i;
    tick();
    check("bp_c_instr", out_instr, c_i);
    in_valid = 1'b0;
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Interlock: mult rd=5 then add rs=5 stalls for 4 cycles.
    m5   = mk(5'd0, 5'd5, 5'd1, 5'd2, 5'd6);
    add5 = mk(5'd0, 5'd7, 5'd5, 5'd3, 5'd0);
    in_valid = 1'b1; in_instr = m5;
    tick();
    check("mult_ctrl", 32'(obs()), 32'(C_WEREG | C_WEST | C_ALUOP | C_MULT | C_MDS));
    in_instr = add5;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      check("dep_stall", 32'(stall), 32'd1);
      check("dep_md_busy", 32'(md_busy), 32'd1);
      if (k == 2) check("md_start_pulse", 32'(out_md_start), 32'd0);
      tick();
    end
    @(negedge clock);
    check("dep_free_stall", 32'(stall), 32'd0);
    check("dep_free_busy", 32'(md_busy), 32'd0);
    check("dep_free_ready", 32'(in_ready), 32'd1);
    tick();
    check("dep_accept_instr", out_instr, add5);
    in_valid = 1'b0;
    tick();

    // Independent add (r6) issues right behind the mult.
    add6 = mk(5'd0, 5'd6, 5'd6, 5'd6, 5'd0);
    in_valid = 1'b1; in_instr = m5;
    tick();
    in_instr = add6;
    @(negedge clock);
    check("indep_stall", 32'(stall), 32'd0);
    check("indep_busy", 32'(md_busy), 32'd1);
    tick();
    check("indep_instr", out_instr, add6);
    in_valid = 1'b0;
    busy_cycles = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (!md_busy) break;
      busy_cycles++;
      tick();
    end
    check("busy_length", 32'(busy_cycles), 32'd4);
    tick();

    // mult rd=0: r0 never conflicts, but a following div must wait.
    m0   = mk(5'd0, 5'd0, 5'd1, 5'd2, 5'd6);
    add0 = mk(5'd0, 5'd4, 5'd0, 5'd0, 5'd0);
    dv   = mk(5'd0, 5'd3, 5'd1, 5'd2, 5'd7);
    bx   = mk(5'd10, 5'd0, 5'd0, 5'd0, 5'd0);
    in_valid = 1'b1; in_instr = m0;
    tick();
    in_instr = add0;
    @(negedge clock);
    check("r0_stall", 32'(stall), 32'd0);
    tick();
    check("r0_instr", out_instr, add0);
    in_instr = dv;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clock);
      check("div_stall", 32'(stall), 32'd1);
      tick();
    end
    @(negedge clock);
    check("div_free_stall", 32'(stall), 32'd0);
    tick();
    check("div_instr", out_instr, dv);
    check("div_ctrl", 32'(obs()), 32'(C_WEREG | C_WEST | C_ALUOP | C_DIV | C_MDS));
    in_instr = bx;
    @(negedge clock);
    check("bex_stall", 32'(stall), 32'd1);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("bex_released", 32'(got), 32'd1);
    tick();
    check("bex_instr", out_instr, bx);
    check("bex_ctrl", 32'(obs()), 32'(C_BEX));
    in_valid = 1'b0;
    tick();

    // Flush with a held bundle and a busy mult.
    m9 = mk(5'd0, 5'd9, 5'd1, 5'd2, 5'd6);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = m9;
    tick();
    in_instr = add6; flush = 1'b1;
    @(negedge clock);
    check("fl_valid_before", 32'(out_valid), 32'd1);
    check("fl_busy_before", 32'(md_busy), 32'd1);
    check("fl_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_valid_after", 32'(out_valid), 32'd0);
    check("fl_busy_after", 32'(md_busy), 32'd1);
    tick(); tick();
    @(negedge clock);
    check("fl_busy_c4", 32'(md_busy), 32'd1);
    tick();
    check("fl_busy_end", 32'(md_busy), 32'd0);

    // Reset in the middle of a busy mult.
    in_valid = 1'b1; in_instr = m9;
    tick();
    in_valid = 1'b0;
    check("mr_busy", 32'(md_busy), 32'd1);
    reset = 1'b1;
    tick();
    check("mr_busy_cleared", 32'(md_busy), 32'd0);
    check("mr_valid_cleared", 32'(out_valid), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("mr_in_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, parametrised control-decode pipeline stage for the 5-bit-opcode 32-bit ISA. It accepts one instruction per cycle over a valid/ready handshake and emits a registered control bundle. It tracks the in-flight multi-cycle mult/div operation and stalls dependent or conflicting instructions until that operation completes. It sits between fetch/IF-ID and the register-read/execute stage, and drives the multdiv unit's start.

Parameters:
OPW, 5, opcode and ALU-opcode field width.
MD_CYCLES, 32, multdiv latency in cycles; legal range is 1 or more.
MD_HAZARD, 1, 1 enables the mult/div interlock; 0 makes md_busy and stall constant 0.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  upstream instruction valid.
in_ready  out  1  stage can accept this cycle.
in_instr  in  32  instruction. Fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU-op [6:2].
flush  in  1  squash the held output and refuse input this cycle.
out_valid  out  1  control bundle valid.
out_ready  in  1  downstream accepts the bundle.
out_instr  out  32  registered copy of the instruction.
out_jump, out_j2, out_bne, out_blt, out_bex  out  1 each  control-flow controls.
out_weDM, out_weReg, out_weRegDM, out_weStatus, out_weReturn  out  1 each  write enables.
out_ALUop, out_immediate  out  1 each  ALU controls.
out_mult, out_div, out_md_start  out  1 each  multdiv controls.
md_busy  out  1  a mult/div is in flight.
stall  out  1  in_valid is held off by the interlock.

Behaviour:
- Reset:
  - Every output register is 0.
  - out_valid=0, md_busy=0, counter=0.
  - in_ready follows the equation below; it is therefore 1 after reset when flush=0.
- Opcode decode:
  - alu=0, j=1, bne=2, jal=3, jr=4, addi=5, blt=6, sw=7, lw=8, setx=9, bex=10. All other opcodes decode to all-zero controls.
  - mult: opcode 0 with ALU-op 6. div: opcode 0 with ALU-op 7.
- Control equations:
  - jump = j|jal|jr
  - j2 = jr
  - weDM = sw
  - weReg = alu|jal|addi|lw|setx
  - weRegDM = lw
  - ALUop = alu|addi
  - immediate = bne|lw|sw|blt|addi
  - weStatus = alu|setx|addi
  - weReturn = jal
  - out_md_start = out_valid & (out_mult|out_div)
- Handshake:
  - hazard is defined under Interlock.
  - in_ready = !flush & !hazard & (!out_valid | out_ready).
  - accept = in_valid & in_ready. On accept, all out_* load the decode of in_instr and out_valid←1.
  - Else if out_valid & out_ready, out_valid←0.
  - Else the outputs hold.
  - Latency: 1 cycle from accept to out_valid.
  - A bundle is held stable while out_valid & !out_ready.
- Flush:
  - flush has priority over everything else: out_valid←0 next edge, no accept.
  - md_busy and the counter are unaffected; an issued op keeps running.
- Interlock (MD_HAZARD=1):
  - On accept of a mult/div: md_busy←1, counter←MD_CYCLES-1, md_rd←rd.
  - While busy: the counter decrements each cycle. When busy and counter==0, md_busy←0 at the next edge.
  - Result: md_busy is high for exactly MD_CYCLES cycles after the accepting edge.
  - hazard = md_busy & (new op is mult/div | bex | any of rd/rs/rt == md_rd with md_rd != 0).
  - Register 0 never conflicts.
  - stall = in_valid & hazard.
- Simultaneous events:
  - Busy clearing and a new mult/div arriving in the same cycle: the new op waits one cycle, because hazard uses the registered md_busy.
  - reset mid-operation clears busy immediately.
- Widths: the counter is $clog2(MD_CYCLES+1) bits. There is no wrap, because the counter stops at 0.

Decomposition:
- Shared package decode_pkg holds:
  - opcode constants, ALU-op constants MULT=6 and DIV=7;
  - field bit positions;
  - a ctrl_t struct of the 15 control bits.
- One combinational sub-module, ctrl_decode, maps instr to ctrl_t and is reused by later stages.
- decode_stage itself holds the handshake register, flush handling and interlock.

Test Plan:
1. Reset with in_valid=0 → all outputs 0. Release → in_ready=1, md_busy=0.
2. Stream add, addi, lw, sw, jal, jr with out_ready=1 → each bundle appears 1 cycle after accept with the listed controls. Example: lw gives weReg=1, weRegDM=1, immediate=1; jal gives jump=1, weReturn=1, weReg=1.
3. Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, bundle held. Release → one bundle per cycle, nothing dropped or duplicated.
4. MD_CYCLES=4: mult rd=5 accepted at edge 0, then add rs=5 presented continuously → stall=1 for cycles 1–4, md_busy=1 for cycles 1–4, add accepted at edge 5. An add using r6 instead is accepted at edge 1.
5. mult rd=0, then add with rs=0 → no stall. A div following that mult stalls until md_busy clears.
6. flush asserted with out_valid=1 and md_busy=1 → out_valid=0 next cycle, md_busy still ends on schedule. reset during busy → md_busy=0 next cycle.
